// File: rtl/mux_scan_lut.sv
// mux_scan_lut -- registered 2^SEL_W:1 data selector with truth-table scan.
//
// Direct mode: y <= g_n ? 0 : d[sel] every edge, y_n is its registered
// complement. A scan (scan_start with g_n low, from IDLE) steps cnt through
// every select code. It captures d[k] into scan_tt[k] and drives y with the
// captured bit. scan_done pulses for one cycle when the last code is captured.
// Raising g_n during a scan aborts it. The abort keeps the bits captured so
// far and does not pulse scan_done.
//
// Optional build macro MUX_SCAN_COMPARE_EN adds the exp_tt input and the
// scan_match register. scan_match is set on the completing edge when the
// captured table equals exp_tt.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   g_n             active-low strobe (high: y=0, aborts scan)
//   sel             direct-mode select code
//   d               N data inputs
//   scan_start      scan request (level, sampled each edge)
//   y, y_n          registered output and complement
//   scan_busy       high while scanning
//   scan_done       one-cycle completion pulse
//   scan_tt         captured truth table
//   exp_tt          expected table      (MUX_SCAN_COMPARE_EN only)
//   scan_match      compare result      (MUX_SCAN_COMPARE_EN only)
module mux_scan_lut #(
  parameter int unsigned SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    g_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [(1<<SEL_W)-1:0]   d,
  input  logic                    scan_start,
  output logic                    y,
  output logic                    y_n,
  output logic                    scan_busy,
  output logic                    scan_done,
`ifdef MUX_SCAN_COMPARE_EN
  output logic [(1<<SEL_W)-1:0]   scan_tt,
  input  logic [(1<<SEL_W)-1:0]   exp_tt,
  output logic                    scan_match
`else
  output logic [(1<<SEL_W)-1:0]   scan_tt
`endif
);

  localparam int unsigned N = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   cnt;
  logic               direct_y;
  logic               last_step;

  always_comb begin
    direct_y  = g_n ? 1'b0 : d[sel];
    last_step = (cnt == SEL_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      y          <= 1'b0;
      y_n        <= 1'b1;
      scan_tt    <= '0;
`ifdef MUX_SCAN_COMPARE_EN
      scan_match <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (scan_start && !g_n) begin
            // y/y_n hold on the accepting edge
            state   <= SCAN;
            cnt     <= '0;
            scan_tt <= '0;
          end else begin
            y   <= direct_y;
            y_n <= ~direct_y;
          end
        end
        SCAN: begin
          if (g_n) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= 1'b0;
            y_n   <= 1'b1;
          end else begin
            scan_tt[cnt] <= d[cnt];
            y            <= d[cnt];
            y_n          <= ~d[cnt];
            cnt          <= cnt + 1'b1;
            if (last_step) begin
              state <= DONE;
`ifdef MUX_SCAN_COMPARE_EN
              // scan_tt[N-1] is written on this same edge, so use d directly
              scan_match <= ({d[N-1], scan_tt[N-2:0]} == exp_tt);
`endif
            end
          end
        end
        default: begin
          // DONE: back to IDLE, direct-mode output resumes on this edge
          state <= IDLE;
          y     <= direct_y;
          y_n   <= ~direct_y;
        end
      endcase
    end
  end

  always_comb begin
    scan_busy = (state == SCAN);
    scan_done = (state == DONE);
  end

endmodule

// File: tb/tb_mux_scan_lut.sv
module tb_mux_scan_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       g_n;
  logic [2:0] sel;
  logic [7:0] d;
  logic       scan_start;
  logic       y, y_n, scan_busy, scan_done;
  logic [7:0] scan_tt;
  logic [7:0] exp_tt;
  logic       scan_match;

  logic       g_n2;
  logic [1:0] sel2;
  logic [3:0] d2;
  logic       scan_start2;
  logic       y2, y2_n, scan_busy2, scan_done2;
  logic [3:0] scan_tt2;
  logic [3:0] exp_tt2;
  logic       scan_match2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_scan_lut #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .g_n(g_n), .sel(sel), .d(d),
    .scan_start(scan_start), .y(y), .y_n(y_n),
    .scan_busy(scan_busy), .scan_done(scan_done),
`ifdef MUX_SCAN_COMPARE_EN
    .scan_tt(scan_tt), .exp_tt(exp_tt), .scan_match(scan_match)
`else
    .scan_tt(scan_tt)
`endif
  );

  mux_scan_lut #(.SEL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .g_n(g_n2), .sel(sel2), .d(d2),
    .scan_start(scan_start2), .y(y2), .y_n(y2_n),
    .scan_busy(scan_busy2), .scan_done(scan_done2),
`ifdef MUX_SCAN_COMPARE_EN
    .scan_tt(scan_tt2), .exp_tt(exp_tt2), .scan_match(scan_match2)
`else
    .scan_tt(scan_tt2)
`endif
  );

`ifndef MUX_SCAN_COMPARE_EN
  initial begin
    scan_match  = 1'b0;
    scan_match2 = 1'b0;
  end
`endif

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs from just after the accepting edge until scan_done, bounded.
  task automatic run_scan(output int busy_cycles, output bit done_seen);
    busy_cycles = 0;
    done_seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (scan_done) begin
        done_seen = 1'b1;
        break;
      end
      if (scan_busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d = 8'hFF; g_n = 1'b0; sel = 3'd7; scan_start = 1'b0;
    exp_tt = 8'h00;
    d2 = 4'hF; g_n2 = 1'b0; sel2 = 2'd3; scan_start2 = 1'b0; exp_tt2 = 4'h0;
    tick(); tick();
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL reset_y got=%b exp=0", y); end
    checks++; if (y_n !== 1'b1) begin errors++; $display("FAIL reset_y_n got=%b exp=1", y_n); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", scan_busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", scan_done); end
    checks++; if (scan_tt !== 8'h00) begin errors++; $display("FAIL reset_tt got=%h exp=00", scan_tt); end
    checks++; if (scan_match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", scan_match); end
    checks++; if (y2 !== 1'b0 || scan_tt2 !== 4'h0) begin
      errors++; $display("FAIL reset_dut2 y=%b tt=%h exp y=0 tt=0", y2, scan_tt2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [7:0] exp_y;
    exp_y = 8'b0101_0010;   // expected y for sel=0..7, bit k
    d = 8'b0101_0010; g_n = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      checks++;
      if (y !== exp_y[s] || y_n !== ~exp_y[s]) begin
        errors++; $display("FAIL direct_sel%0d y=%b y_n=%b exp y=%b", s, y, y_n, exp_y[s]);
      end
    end
    g_n = 1'b1; sel = 3'd1;
    tick();
    checks++; if (y !== 1'b0 || y_n !== 1'b1) begin
      errors++; $display("FAIL direct_strobe y=%b y_n=%b exp y=0 y_n=1", y, y_n);
    end
  endtask

  task automatic full_scan(input logic [7:0] exp, input logic exp_m, input string tag);
    int  nb;
    bit  ds;
    d = 8'h34; g_n = 1'b0; exp_tt = exp; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    run_scan(nb, ds);
    checks++; if (!ds) begin errors++; $display("FAIL %s_done_timeout got=0 exp=1", tag); end
    checks++; if (nb != 8) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=8", tag, nb); end
    checks++; if (scan_tt !== 8'h34) begin errors++; $display("FAIL %s_tt got=%h exp=34", tag, scan_tt); end
`ifdef MUX_SCAN_COMPARE_EN
    checks++; if (scan_match !== exp_m) begin errors++; $display("FAIL %s_match got=%b exp=%b", tag, scan_match, exp_m); end
`endif
    tick();
    checks++; if (scan_done !== 1'b0 || scan_busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_width done=%b busy=%b exp 0 0", tag, scan_done, scan_busy);
    end
    checks++; if (scan_tt !== 8'h34) begin errors++; $display("FAIL %s_tt_hold got=%h exp=34", tag, scan_tt); end
  endtask

  task automatic test_scan();
    full_scan(8'h35, 1'b0, "scan_mis");
    full_scan(8'h34, 1'b1, "scan_hit");
  endtask

  task automatic test_abort();
    int dn;
    d = 8'hFF; g_n = 1'b0; exp_tt = 8'h07; scan_start = 1'b1;
    tick();                 // E0
    scan_start = 1'b0;
    tick(); tick(); tick(); // E1..E3, now in 4th busy cycle
    checks++; if (y !== 1'b1 || scan_busy !== 1'b1) begin
      errors++; $display("FAIL abort_prefix y=%b busy=%b exp 1 1", y, scan_busy);
    end
    g_n = 1'b1;
    tick();
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", scan_busy); end
    checks++; if (scan_tt !== 8'h07) begin errors++; $display("FAIL abort_tt got=%h exp=07", scan_tt); end
    checks++; if (y !== 1'b0 || y_n !== 1'b1) begin errors++; $display("FAIL abort_y y=%b y_n=%b exp 0 1", y, y_n); end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (scan_done) dn++;
      tick();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
`ifdef MUX_SCAN_COMPARE_EN
    checks++; if (scan_match !== 1'b1) begin errors++; $display("FAIL abort_match_hold got=%b exp=1", scan_match); end
`endif
    checks++; if (scan_tt !== 8'h07) begin errors++; $display("FAIL abort_tt_hold got=%h exp=07", scan_tt); end
  endtask

  task automatic test_ignored_start();
    int  nb;
    bit  ds;
    g_n = 1'b1; scan_start = 1'b1;
    tick(); tick();
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL ign_gated busy=%b exp=0", scan_busy); end
    d = 8'h34; g_n = 1'b0; exp_tt = 8'h34;
    tick();                 // accepted
    run_scan(nb, ds);
    checks++; if (!ds || nb != 8) begin
      errors++; $display("FAIL ign_first_scan done=%0d busy=%0d exp 1 8", ds, nb);
    end
    tick();
    checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin
      errors++; $display("FAIL ign_gap busy=%b done=%b exp 0 0", scan_busy, scan_done);
    end
    tick();
    checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL ign_restart busy=%b exp=1", scan_busy); end
    scan_start = 1'b0;
    run_scan(nb, ds);
    checks++; if (!ds || nb != 8 || scan_tt !== 8'h34) begin
      errors++; $display("FAIL ign_second_scan done=%0d busy=%0d tt=%h exp 1 8 34", ds, nb, scan_tt);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int dn;
    d = 8'hFF; g_n = 1'b0; scan_start = 1'b1;
    tick();                 // E0
    scan_start = 1'b0;
    tick(); tick(); tick(); tick(); // E1..E4, 5th busy cycle
    rst_n = 1'b0;
    tick();
    checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags busy=%b done=%b exp 0 0", scan_busy, scan_done);
    end
    checks++; if (y !== 1'b0 || y_n !== 1'b1) begin errors++; $display("FAIL rstmid_y y=%b y_n=%b exp 0 1", y, y_n); end
    checks++; if (scan_tt !== 8'h00 || scan_match !== 1'b0) begin
      errors++; $display("FAIL rstmid_tt tt=%h match=%b exp 00 0", scan_tt, scan_match);
    end
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (scan_done) dn++;
      tick();
    end
    checks++; if (dn != 0 || scan_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_done done=%0d busy=%b exp 0 0", dn, scan_busy);
    end
  endtask

  task automatic test_scan_n4();
    int nb;
    bit ds;
    d2 = 4'b1001; g_n2 = 1'b0; exp_tt2 = 4'h9; scan_start2 = 1'b1;
    tick();
    scan_start2 = 1'b0;
    nb = 0; ds = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (scan_done2) begin ds = 1'b1; break; end
      if (scan_busy2) nb++;
      tick();
    end
    checks++; if (!ds || nb != 4) begin errors++; $display("FAIL n4_scan done=%0d busy=%0d exp 1 4", ds, nb); end
    checks++; if (scan_tt2 !== 4'h9) begin errors++; $display("FAIL n4_tt got=%h exp=9", scan_tt2); end
`ifdef MUX_SCAN_COMPARE_EN
    checks++; if (scan_match2 !== 1'b1) begin errors++; $display("FAIL n4_match got=%b exp=1", scan_match2); end
`endif
    tick();
    checks++; if (scan_done2 !== 1'b0) begin errors++; $display("FAIL n4_done_width got=%b exp=0", scan_done2); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_abort();
    test_ignored_start();
    test_reset_mid_scan();
    test_scan_n4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
